// File: rtl/addsub_accum.sv
`default_nettype none
// ============================================================================
// Module   : addsub_accum (with helper add_sub)
// Brief    : Streaming signed add/subtract accumulator with a registered
//            valid/ready result carrying overflow flag and beat count.
//            Define ADDSUB_ACC_SAT_EN to clamp overflowing results.
// Revision : 1.0  initial release
// ============================================================================

module add_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sign,
  output logic [WIDTH-1:0] z
);

  assign z = sign ? (x - y) : (x + y);

endmodule

module addsub_accum #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [7:0]       out_beats
);

  localparam logic [7:0] C_CNT_MAX = 8'd255;

  logic [WIDTH-1:0] r_acc;
  logic             r_ovf_st;
  logic [7:0]       r_cnt;

  logic [WIDTH-1:0] w_z;
  logic [WIDTH-1:0] w_wr_val;
  logic             w_beat_ovf;
  logic             w_accept;
  logic [7:0]       w_cnt_next;
  logic             w_x_msb;
  logic             w_y_msb;
  logic             w_z_msb;

  add_sub #(
    .WIDTH (WIDTH)
  ) u_add_sub (
    .x    (r_acc),
    .y    (in_data),
    .sign (in_sub),
    .z    (w_z)
  );

  assign w_x_msb = r_acc[WIDTH-1];
  assign w_y_msb = in_data[WIDTH-1];
  assign w_z_msb = w_z[WIDTH-1];

  // Subtraction overflows when operands differ in sign; addition when they agree.
  assign w_beat_ovf = in_sub ? ((w_x_msb != w_y_msb) && (w_z_msb != w_x_msb))
                             : ((w_x_msb == w_y_msb) && (w_z_msb != w_x_msb));

`ifdef ADDSUB_ACC_SAT_EN
  // On any overflow the true result has the sign of the accumulator operand.
  logic [WIDTH-1:0] w_sat_val;
  assign w_sat_val = w_x_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_wr_val  = w_beat_ovf ? w_sat_val : w_z;
`else
  assign w_wr_val  = w_z;
`endif

  assign w_cnt_next = (r_cnt == C_CNT_MAX) ? C_CNT_MAX : (r_cnt + 8'd1);
  assign in_ready   = rst_n && (!out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_ovf_st  <= 1'b0;
      r_cnt     <= 8'd0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_beats <= 8'd0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (in_last) begin
          out_data  <= w_wr_val;
          out_ovf   <= r_ovf_st | w_beat_ovf;
          out_beats <= w_cnt_next;
          out_valid <= 1'b1;
          r_acc     <= '0;
          r_ovf_st  <= 1'b0;
          r_cnt     <= 8'd0;
        end else begin
          r_acc     <= w_wr_val;
          r_ovf_st  <= r_ovf_st | w_beat_ovf;
          r_cnt     <= w_cnt_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_accum
// Brief    : Scoreboard bench for addsub_accum at WIDTH=8; honours
//            ADDSUB_ACC_SAT_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_addsub_accum;

  localparam int    W    = 8;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W-1));

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
    logic [7:0]   beats;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_sub = 1'b0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic [7:0]   out_beats;

  int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  logic rand_ready = 1'b1;
  assign out_ready = (ready_mode == 2) ? rand_ready : (ready_mode == 1);

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic signed [W-1:0] m_acc = '0;
  bit                  m_ovf = 1'b0;
  int                  m_cnt = 0;

  addsub_accum #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_beats (out_beats)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      rand_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then range test for overflow.
  task automatic model_accept(input logic [W-1:0] d, input bit sub, input bit last);
    longint       t;
    bit           ov;
    logic [W-1:0] wv;
    int           nc;
    t  = sub ? (longint'(m_acc) - longint'($signed(d))) : (longint'(m_acc) + longint'($signed(d)));
    ov = (t > MAXV) || (t < MINV);
`ifdef ADDSUB_ACC_SAT_EN
    wv = ov ? ((t > 0) ? W'(MAXV) : W'(MINV)) : W'(t);
`else
    wv = W'(t);
`endif
    nc = (m_cnt >= 255) ? 255 : m_cnt + 1;
    if (last) begin
      exp_q.push_back('{data: wv, ovf: m_ovf | ov, beats: 8'(nc)});
      m_acc = '0; m_ovf = 1'b0; m_cnt = 0;
    end else begin
      m_acc = $signed(wv); m_ovf = m_ovf | ov; m_cnt = nc;
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input logic [W-1:0] d, input bit sub, input bit last);
    int guard = 0;
    in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last;
    #1;
    while (!in_ready && guard < 300) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("send_timeout", 1, 0);
      @(negedge clk);
    end else begin
      @(posedge clk);
      model_accept(d, sub, last);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Monitor: pops one expectation for every newly presented result and
  // checks that a held result neither changes nor disappears.
  initial begin
    bit   vprev = 1'b0;
    bit   hsprev = 1'b0;
    res_t e = '0;
    res_t held = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        vprev = 1'b0; hsprev = 1'b0;
      end else begin
        if (out_valid && (!vprev || hsprev)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_ovf", out_ovf, e.ovf);
            check("out_beats", out_beats, e.beats);
            held = e;
          end
        end else if (out_valid) begin
          check("hold_data", out_data, held.data);
        end else if (vprev && !hsprev) begin
          check("valid_dropped", out_valid, 1);
        end
        vprev = out_valid;
      end
      @(negedge clk); #1;
      hsprev = out_valid && out_ready;
    end
  end

  task automatic check_reset_state();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_beats", out_beats, 0);
    check("rst_in_ready", in_ready, 0);
  endtask

  initial begin
    int n;
    int guard;
    ready_mode = 1;
    #1;
    check_reset_state();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", in_ready, 1);
    @(negedge clk);

    // Reset mid-packet discards the partial sum.
    send(8'd5, 0, 0);
    send(8'd7, 0, 0);
    rst_n = 1'b0;
    m_acc = '0; m_ovf = 1'b0; m_cnt = 0;
    exp_q.delete();
    #1;
    check_reset_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'd3, 0, 1);
    #1;
    check("post_rst_data", out_data, 3);
    check("post_rst_beats", out_beats, 1);
    check("post_rst_ovf", out_ovf, 0);
    @(negedge clk);

    // Mixed packet; result valid for exactly one cycle.
    send(8'd10, 0, 0);
    send(8'd4, 1, 0);
    send(8'd20, 0, 0);
    send(8'd1, 1, 1);
    #1;
    check("mixed_valid", out_valid, 1);
    check("mixed_data", out_data, 25);
    check("mixed_beats", out_beats, 4);
    @(negedge clk); #1;
    check("mixed_valid_drop", out_valid, 0);
    @(negedge clk);

    // Positive and negative overflow.
    send(8'd100, 0, 0);
    send(8'd100, 0, 1);
    #1;
`ifdef ADDSUB_ACC_SAT_EN
    check("ovf_pos_data", out_data, 8'd127);
`else
    check("ovf_pos_data", out_data, 8'hC8);
`endif
    check("ovf_pos_flag", out_ovf, 1);
    @(negedge clk);
    send(8'd100, 1, 0);
    send(8'd100, 1, 1);
    #1;
`ifdef ADDSUB_ACC_SAT_EN
    check("ovf_neg_data", out_data, 8'h80);
`else
    check("ovf_neg_data", out_data, 8'h38);
`endif
    check("ovf_neg_flag", out_ovf, 1);
    @(negedge clk);

    // Back-pressure: second packet waits until out_ready rises.
    ready_mode = 0;
    send(8'd1, 0, 1);
    fork
      send(8'd2, 0, 1);
      begin
        repeat (5) begin
          #1;
          check("bp_data", out_data, 1);
          check("bp_in_ready", in_ready, 0);
          @(negedge clk);
        end
        ready_mode = 1;
      end
    join
    #1;
    check("bp_release_data", out_data, 2);
    @(negedge clk);

    // Back-to-back single-beat packets at full throughput.
    for (int k = 1; k <= 3; k++) begin
      send(W'(k), 0, 1);
      #1;
      check("b2b_valid", out_valid, 1);
      check("b2b_data", out_data, k);
    end
    @(negedge clk);

    // Beat counter saturation.
    repeat (300) send(8'd0, 0, 0);
    send(8'd0, 0, 1);
    #1;
    check("sat_beats", out_beats, 255);
    check("sat_data", out_data, 0);
    @(negedge clk);

    // Randomized packets under random back-pressure.
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) begin
        send(W'($urandom), bit'($urandom_range(0, 1)), b == n - 1);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    ready_mode = 1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
